// File: rtl/canvas_streamer.sv
// canvas_streamer: streams a 28x28 canvas of 16-bit pixels in raster order
// over a valid/ready handshake. It freezes the editor (Hold) while streaming,
// and reports the nonzero-pixel count of each completed frame.
module canvas_streamer (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [27:0][27:0][15:0]    canvas,
  input  logic                       Pixel_Ready,
  output logic [15:0]                Pixel_Data,
  output logic [9:0]                 Pixel_Index,
  output logic                       Pixel_Valid,
  output logic                       Pixel_Last,
  output logic                       Hold,
  output logic                       Done,
  output logic [9:0]                 Ink_Count,
  output logic                       Empty
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_COL = 5'd27;
  localparam logic [9:0] LAST_IDX = 10'd783;

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [9:0]  idx_q, idx_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  ink_q, ink_d;
  logic        empty_q, empty_d;

  logic        start_edge;
  logic        xfer;
  logic        at_last;
  logic        pix_nz;
  logic [9:0]  cnt_next;

  // Pixel data comes straight from the canvas at the current position.
  assign Pixel_Data  = canvas[row_q][col_q];
  assign Pixel_Index = idx_q;
  assign Pixel_Valid = (state_q == S_STREAM);
  assign Hold        = (state_q == S_STREAM);
  assign Done        = (state_q == S_DONE);
  assign Pixel_Last  = Pixel_Valid & (idx_q == LAST_IDX);
  assign Ink_Count   = ink_q;
  assign Empty       = empty_q;

  // Next-state, position, and ink-count logic.
  always_comb begin
    state_d    = state_q;
    start_d    = Start;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ink_d      = ink_q;
    empty_d    = empty_q;
    start_edge = Start & ~start_q;
    xfer       = (state_q == S_STREAM) & Pixel_Ready;
    at_last    = (idx_q == LAST_IDX);
    pix_nz     = (Pixel_Data != 16'h0000);
    cnt_next   = cnt_q + {9'd0, pix_nz};

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_STREAM;
          row_d   = 5'd0;
          col_d   = 5'd0;
          idx_d   = 10'd0;
          cnt_d   = 10'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          cnt_d = cnt_next;
          if (at_last) begin
            // Publish the final count so it is visible during the DONE cycle.
            state_d = S_DONE;
            ink_d   = cnt_next;
            empty_d = (cnt_next == 10'd0);
          end else if (col_q == LAST_COL) begin
            col_d = 5'd0;
            row_d = row_q + 5'd1;
            idx_d = idx_q + 10'd1;
          end else begin
            col_d = col_q + 5'd1;
            idx_d = idx_q + 10'd1;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers, with synchronous reset taking priority over all activity.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      row_q   <= 5'd0;
      col_q   <= 5'd0;
      idx_q   <= 10'd0;
      cnt_q   <= 10'd0;
      ink_q   <= 10'd0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ink_q   <= ink_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_canvas_streamer.sv
// Scoreboard bench for canvas_streamer: stimulus queues expected transfers,
// a negedge monitor pops and compares each accepted pixel.
module tb_canvas_streamer;

  logic                    Clk;
  logic                    Reset;
  logic                    Start;
  logic [27:0][27:0][15:0] cv;
  logic                    Pixel_Ready;
  logic [15:0]             Pixel_Data;
  logic [9:0]              Pixel_Index;
  logic                    Pixel_Valid;
  logic                    Pixel_Last;
  logic                    Hold;
  logic                    Done;
  logic [9:0]              Ink_Count;
  logic                    Empty;

  canvas_streamer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .canvas(cv),
    .Pixel_Ready(Pixel_Ready), .Pixel_Data(Pixel_Data),
    .Pixel_Index(Pixel_Index), .Pixel_Valid(Pixel_Valid),
    .Pixel_Last(Pixel_Last), .Hold(Hold), .Done(Done),
    .Ink_Count(Ink_Count), .Empty(Empty)
  );

  typedef struct {
    logic [9:0]  idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_cyc = -10;
  int hold_cycles = 0;
  int xfers = 0;
  int done_cnt = 0;
  int bp = 0;
  int bp_phase = 0;
  logic        stalled = 1'b0;
  logic [9:0]  held_idx = 10'd0;
  logic [15:0] held_data = 16'd0;
  logic        bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scenario-specific expected pixel, derived from how each canvas is drawn.
  function automatic logic [15:0] exp_pix(input int scen, input int idx);
    int r;
    int c;
    r = idx / 28;
    c = idx % 28;
    case (scen)
      0: return (idx == 89) ? 16'h00FF : 16'h0000;
      2: return (idx < 50) ? 16'(idx + 1) : 16'h0000;
      3: begin
        if (c == 27) return 16'(r + 1);
        else if (c == 0 && r > 0) return 16'h8000;
        else return 16'h0000;
      end
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_frame(input int scen);
    exp_t e;
    for (int i = 0; i < 784; i++) begin
      e.idx  = 10'(i);
      e.data = exp_pix(scen, i);
      e.last = (i == 783);
      sb.push_back(e);
    end
    hold_cycles = 0;
    xfers = 0;
  endtask

  // Backpressure driver: Ready pattern 1,0,0,1 applied just after each rising edge.
  always @(posedge Clk) begin
    #1;
    if (bp != 0) begin
      Pixel_Ready = bp_pat[bp_phase];
      bp_phase = (bp_phase + 1) % 4;
    end
  end

  // Monitor: checks each transfer against the scoreboard, stall stability and Done timing.
  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (Reset) begin
      stalled = 1'b0;
    end else begin
      if (Hold) hold_cycles++;
      if (stalled && Pixel_Valid) begin
        chk("stall_idx", 32'(Pixel_Index), 32'(held_idx));
        chk("stall_data", 32'(Pixel_Data), 32'(held_data));
      end
      if (Pixel_Valid && Pixel_Ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_xfer", 32'(Pixel_Index), 32'h3ff);
        end else begin
          e = sb.pop_front();
          chk("xfer_idx", 32'(Pixel_Index), 32'(e.idx));
          chk("xfer_data", 32'(Pixel_Data), 32'(e.data));
          chk("xfer_last", 32'(Pixel_Last), 32'(e.last));
          if (e.last) last_cyc = cyc;
        end
        xfers++;
      end
      stalled   = Pixel_Valid && !Pixel_Ready;
      held_idx  = Pixel_Index;
      held_data = Pixel_Data;
      if (Done) begin
        done_cnt++;
        chk("done_after_last", 32'(cyc), 32'(last_cyc + 1));
      end
    end
  end

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_idx(input int idx);
    int n;
    for (n = 0; n < 4000; n++) begin
      @(negedge Clk);
      if (Pixel_Valid && Pixel_Index == 10'(idx)) break;
    end
    if (n == 4000) chk("wait_idx_timeout", 32'(n), 32'(idx));
  endtask

  task automatic wait_done(input int exp_ink, input bit check_hold);
    int n;
    int d0;
    d0 = done_cnt;
    for (n = 0; n < 4000; n++) begin
      @(negedge Clk);
      if (Done) break;
    end
    if (n == 4000) begin
      chk("done_timeout", 32'(n), 32'(0));
    end else begin
      chk("ink_at_done", 32'(Ink_Count), 32'(exp_ink));
      chk("empty_at_done", 32'(Empty), 32'(exp_ink == 0));
      chk("valid_in_done", 32'(Pixel_Valid), 32'(0));
      chk("hold_in_done", 32'(Hold), 32'(0));
      chk("xfer_count", 32'(xfers), 32'(784));
      chk("sb_drained", 32'(sb.size()), 32'(0));
      if (check_hold) chk("hold_cycles", 32'(hold_cycles), 32'(784));
      @(negedge Clk);
      chk("done_one_cycle", 32'(Done), 32'(0));
      chk("done_count", 32'(done_cnt), 32'(d0 + 1));
      chk("ink_holds", 32'(Ink_Count), 32'(exp_ink));
      chk("empty_holds", 32'(Empty), 32'(exp_ink == 0));
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Pixel_Ready = 1'b0;
    cv = '0;
    repeat (3) @(negedge Clk);
    chk("rst_valid", 32'(Pixel_Valid), 32'(0));
    chk("rst_hold", 32'(Hold), 32'(0));
    chk("rst_done", 32'(Done), 32'(0));
    chk("rst_ink", 32'(Ink_Count), 32'(0));
    chk("rst_empty", 32'(Empty), 32'(1));
    chk("rst_index", 32'(Pixel_Index), 32'(0));
    Reset = 1'b0;
    Pixel_Ready = 1'b1;
    @(negedge Clk);

    // Full stream, single dot at [3][5]
    cv[3][5] = 16'h00FF;
    push_frame(0);
    pulse_start();
    wait_done(1, 1'b1);

    // Backpressure 1,0,0,1
    push_frame(0);
    bp_phase = 0;
    bp = 1;
    pulse_start();
    wait_done(1, 1'b0);
    bp = 0;
    Pixel_Ready = 1'b1;
    @(negedge Clk);

    // Empty canvas
    cv = '0;
    push_frame(1);
    pulse_start();
    wait_done(0, 1'b1);

    // Start pulsed again mid-stream is ignored
    cv[3][5] = 16'h00FF;
    push_frame(0);
    pulse_start();
    wait_idx(400);
    pulse_start();
    wait_done(1, 1'b1);
    repeat (10) @(negedge Clk);
    chk("no_restart_hold", 32'(hold_cycles), 32'(784));

    // Start held high produces only one stream
    push_frame(0);
    Start = 1'b1;
    wait_done(1, 1'b1);
    repeat (20) @(negedge Clk);
    chk("held_start_hold", 32'(hold_cycles), 32'(784));
    chk("held_start_sb", 32'(sb.size()), 32'(0));
    Start = 1'b0;
    @(negedge Clk);

    // Mid-stream reset on a 50-pixel canvas, restart with Start held through reset
    cv = '0;
    for (int i = 0; i < 50; i++) cv[i / 28][i % 28] = 16'(i + 1);
    push_frame(2);
    pulse_start();
    wait_idx(300);
    Reset = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    chk("mrst_valid", 32'(Pixel_Valid), 32'(0));
    chk("mrst_hold", 32'(Hold), 32'(0));
    chk("mrst_ink", 32'(Ink_Count), 32'(0));
    chk("mrst_empty", 32'(Empty), 32'(1));
    chk("mrst_index", 32'(Pixel_Index), 32'(0));
    sb.delete();
    Reset = 1'b0;
    push_frame(2);
    @(negedge Clk);
    chk("post_rst_valid", 32'(Pixel_Valid), 32'(1));
    chk("post_rst_index", 32'(Pixel_Index), 32'(0));
    Start = 1'b0;
    wait_done(50, 1'b1);

    // Row wrap
    cv = '0;
    for (int r = 0; r < 28; r++) cv[r][27] = 16'(r + 1);
    for (int r = 1; r < 28; r++) cv[r][0] = 16'h8000;
    push_frame(3);
    pulse_start();
    wait_done(55, 1'b1);

    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/canvas_streamer.md
CANVAS_STREAMER -- requirements
Module: canvas_streamer

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high. Ports are named Clk and Reset.
REQ-002 Clk  in  1  system clock (50 MHz domain); all state updates on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high; sampled on a Clk rising edge.
REQ-004 Start  in  1  request to stream the canvas; level input, acted on at its rising edge.
REQ-005 canvas  in  16 x [27:0][27:0]  drawn image, indexed canvas[row][col]; row = Y, col = X.
REQ-006 Pixel_Data  out  16  current pixel value, canvas[row][col].
REQ-007 Pixel_Index  out  10  current pixel position, row*28+col, range 0..783.
REQ-008 Pixel_Valid  out  1  Pixel_Data and Pixel_Index are valid this cycle.
REQ-009 Pixel_Ready  in  1  neural-network side accepts the current pixel.
REQ-010 Pixel_Last  out  1  high together with Pixel_Valid when Pixel_Index = 783.
REQ-011 Hold  out  1  canvas freeze request to the canvas editor; high in STREAM.
REQ-012 Done  out  1  one-cycle pulse after the final transfer.
REQ-013 Ink_Count  out  10  number of nonzero pixels in the last completed frame.
REQ-014 Empty  out  1  high when Ink_Count = 0 (registered).

Function
REQ-015 Start edge detection SHALL use a registered copy start_q. An edge occurs when Start=1 and start_q=0; start_q updates every cycle.
REQ-016 The FSM SHALL have three states: IDLE, STREAM and DONE.
REQ-017 IDLE -> STREAM SHALL occur on a Start edge. In the next cycle: row=0, col=0, Pixel_Valid=1, Hold=1.
REQ-018 A transfer SHALL occur in any cycle where Pixel_Valid=1 and Pixel_Ready=1. Only a transfer advances the position.
REQ-019 The position SHALL advance col 0..27, then wrap to col=0 with row+1. It SHALL NOT advance past row=27, col=27.
REQ-020 While Pixel_Valid=1 and Pixel_Ready=0, Pixel_Index and Pixel_Data SHALL stay at the same position. There is no timeout and no limit on stall length.
REQ-021 Pixel_Data SHALL be driven combinationally from canvas[row][col] at the current position, with zero added latency.
REQ-022 The STREAM -> DONE transition SHALL occur on the transfer with Pixel_Last=1. Pixel_Valid=0 in DONE.
REQ-023 DONE SHALL last exactly one cycle with Done=1, then return to IDLE. Hold=0 in DONE and IDLE.
REQ-024 A Start edge in STREAM or DONE SHALL be ignored; it is not queued.
REQ-025 The running ink counter SHALL be cleared on entry to STREAM and incremented on each transfer with Pixel_Data != 0. It is 10 bits wide; maximum 784, no overflow.
REQ-026 Ink_Count and Empty SHALL be updated in the DONE cycle from the final counter, including the last pixel. They hold that value until the next DONE.
REQ-027 A stream that is aborted (REQ-029) SHALL NOT update Ink_Count or Empty.
REQ-028 Pixel_Last SHALL equal Pixel_Valid AND (Pixel_Index = 783).

Reset
REQ-029 On Reset=1 at any time, including mid-stream, the block SHALL enter IDLE with row=col=0 and start_q=0. All outputs go low: Pixel_Valid=0, Hold=0, Done=0, Ink_Count=0, Empty=1, Pixel_Index=0.
REQ-030 Reset SHALL take priority over Start and transfers in the same cycle.
REQ-031 A Start held high through reset release SHALL start a stream in the first post-reset cycle, because start_q=0 after reset.

Verification
REQ-032 Bench SHALL cover the following directed scenarios:
- Full stream: canvas all 0 except canvas[3][5]=16'h00FF; Start pulse; Ready=1 constantly.
  - 784 transfers in 784 consecutive cycles.
  - Index 0..783 in order; Data=16'h00FF only at Index 89.
  - Last only at 783; Done one cycle later.
  - Ink_Count=1, Empty=0.
- Backpressure: Ready toggles 1,0,0,1 repeating.
  - Index and Data stable during stalls; exactly 784 transfers; order preserved.
  - Ink_Count matches the first scenario.
- Empty canvas: all-zero canvas; Start.
  - Ink_Count=0, Empty=1 at Done; Hold high for exactly 784 cycles with Ready=1.
- Start in STREAM: Start pulsed again at Index 400.
  - No restart; exactly one Done.
  - Start held high continuously produces only one stream.
- Mid-stream reset: Reset at Index 300 of a frame whose canvas has 50 nonzero pixels.
  - Next cycle: Valid=0, Hold=0, Ink_Count=0, Empty=1.
  - A new Start streams again from Index 0.
- Wrap check: canvas[r][27]=r+1 and canvas[r+1][0]=16'h8000, for all r.
  - Data at Index r*28+27 = r+1, and at (r+1)*28 = 16'h8000.
  - Ink_Count=55.
